// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor.
//   op_e         : operation encoding (OP_ADD / OP_SUB)
//   group_count  : number of lookahead groups for a given operand width
//   cfg_ok       : elaboration-time sanity check of WIDTH/GROUP/STAGES
package cla_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int unsigned group_count(int unsigned width, int unsigned group);
    return width / group;
  endfunction

  function automatic bit cfg_ok(int unsigned width, int unsigned group, int unsigned stages);
    if (group == 0 || stages == 0) return 1'b0;
    if (width % group != 0) return 1'b0;
    return ((width / group) % stages) == 0;
  endfunction

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for pipelined_cla_adder.
//   master : producer of operands / consumer of results (testbench, upstream logic)
//   slave  : the adder itself
// Signals: in_valid/in_ready, in1, in2, cin, op on the input side;
//          out_valid/out_ready, sum, cout, ovf on the output side.
interface pipelined_cla_adder_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             cin;
  logic             op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, in1, in2, cin, op, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, in1, in2, cin, op, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/cla_group.sv
// GROUP-bit combinational carry-lookahead block.
//   a, b   : group operand bits (b already conditioned for subtract)
//   c_in   : carry into the group
//   s      : group sum bits
//   p_grp  : group propagate (all bits propagate)
//   g_grp  : group generate (carry out independent of c_in)
//   c_out  : carry out of the group
module cla_group #(
  parameter int unsigned GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             c_in,
  output logic [GROUP-1:0] s,
  output logic             p_grp,
  output logic             g_grp,
  output logic             c_out
);
  logic [GROUP-1:0] p;
  logic [GROUP-1:0] g;
  logic [GROUP:0]   c;

  assign p = a ^ b;
  assign g = a & b;

  // Each carry is a flat sum of products over the lower bits:
  // c[i] = g[i-1] | p[i-1]g[i-2] | ... | p[i-1..0]c_in.
  always_comb begin
    logic term;
    logic prod;
    c     = '0;
    term  = 1'b0;
    prod  = 1'b0;
    c[0]  = c_in;
    for (int unsigned i = 1; i <= GROUP; i++) begin
      term = g[i-1];
      prod = p[i-1];
      for (int unsigned j = i - 1; j >= 1; j--) begin
        term = term | (prod & g[j-1]);
        prod = prod & p[j-1];
      end
      c[i] = term | (prod & c_in);
    end
    // The final product-term sum excludes c_in, which is exactly group G.
    g_grp = term;
  end

  assign p_grp = &p;
  assign s     = p ^ c[GROUP-1:0];
  assign c_out = c[GROUP];
endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake.
//   clk, rst : clock (rising edge), synchronous active-high reset
//   bus      : pipelined_cla_adder_if slave port (operands in, result out)
// WIDTH-bit operands are split into GROUP-bit lookahead groups; STAGES
// register stages each resolve NGROUPS/STAGES groups. Latency is STAGES
// cycles, throughput one operation per cycle, backpressure is lossless.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned GROUP  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  pipelined_cla_adder_if.slave  bus
);
  localparam int unsigned NGROUPS = group_count(WIDTH, GROUP);
  localparam int unsigned GPS     = NGROUPS / STAGES;
  localparam int unsigned LAST    = STAGES - 1;

  if (!cfg_ok(WIDTH, GROUP, STAGES)) begin : g_bad_cfg
    $error("pipelined_cla_adder: WIDTH must be a multiple of GROUP and WIDTH/GROUP of STAGES");
  end

  typedef logic [WIDTH-1:0] word_t;

  // Stage registers. Full operands are carried forward; bits already
  // resolved are never read again and trim away in synthesis.
  word_t a_q   [STAGES];
  word_t b_q   [STAGES];
  word_t sum_q [STAGES];
  logic  op_q    [STAGES];
  logic  c_q     [STAGES];
  logic  valid_q [STAGES];
  logic  ovf_q;

  // Inputs seen by each stage's combinational slice.
  word_t a_src   [STAGES];
  word_t b_src   [STAGES];
  word_t sum_src [STAGES];
  word_t sum_nx  [STAGES];
  logic  op_src    [STAGES];
  logic  c_src     [STAGES];
  logic  valid_src [STAGES];
  logic  c_nx      [STAGES];
  logic  rdy       [STAGES];
  logic  ovf_nx;

  logic [NGROUPS-1:0] gp;
  logic [NGROUPS-1:0] gg;
  logic [NGROUPS-1:0] gcin;
  logic [GROUP-1:0]   gs  [NGROUPS];
  logic               gco [NGROUPS];

  always_comb begin
    a_src[0]     = bus.in1;
    b_src[0]     = bus.in2;
    op_src[0]    = bus.op;
    // Subtract is a + ~b + 1: the +1 enters as the initial carry.
    c_src[0]     = (bus.op == OP_SUB) ? 1'b1 : bus.cin;
    sum_src[0]   = '0;
    valid_src[0] = bus.in_valid;
    for (int unsigned s = 1; s < STAGES; s++) begin
      a_src[s]     = a_q[s-1];
      b_src[s]     = b_q[s-1];
      op_src[s]    = op_q[s-1];
      c_src[s]     = c_q[s-1];
      sum_src[s]   = sum_q[s-1];
      valid_src[s] = valid_q[s-1];
    end
  end

  for (genvar gi = 0; gi < NGROUPS; gi++) begin : g_grp
    localparam int unsigned ST = gi / GPS;
    cla_group #(.GROUP(GROUP)) u_grp (
      .a     (a_src[ST][gi*GROUP +: GROUP]),
      .b     (b_src[ST][gi*GROUP +: GROUP] ^ {GROUP{op_src[ST]}}),
      .c_in  (gcin[gi]),
      .s     (gs[gi]),
      .p_grp (gp[gi]),
      .g_grp (gg[gi]),
      .c_out (gco[gi])
    );
  end

  // Second lookahead level: group carry-ins within a stage are flat
  // sum-of-products over that stage's group P/G and the stage carry-in.
  always_comb begin
    logic term;
    logic prod;
    gcin = '0;
    term = 1'b0;
    prod = 1'b0;
    for (int unsigned s = 0; s < STAGES; s++) begin
      gcin[s*GPS] = c_src[s];
      for (int unsigned k = 1; k < GPS; k++) begin
        term = gg[s*GPS+k-1];
        prod = gp[s*GPS+k-1];
        for (int unsigned j = k - 1; j >= 1; j--) begin
          term = term | (prod & gg[s*GPS+j-1]);
          prod = prod & gp[s*GPS+j-1];
        end
        gcin[s*GPS+k] = term | (prod & c_src[s]);
      end
    end
  end

  always_comb begin
    for (int unsigned s = 0; s < STAGES; s++) begin
      sum_nx[s] = sum_src[s];
      for (int unsigned k = 0; k < GPS; k++) begin
        sum_nx[s][(s*GPS+k)*GROUP +: GROUP] = gs[s*GPS+k];
      end
      c_nx[s] = gco[s*GPS+GPS-1];
    end
    ovf_nx = (a_src[LAST][WIDTH-1] == (b_src[LAST][WIDTH-1] ^ op_src[LAST])) &&
             (sum_nx[LAST][WIDTH-1] != a_src[LAST][WIDTH-1]);
  end

  // Ready chain walks from the output back to the input; each stage only
  // reads the ready of the stage after it, so there is no loop.
  always_comb begin
    logic r;
    r = bus.out_ready;
    for (int unsigned i = 0; i < STAGES; i++) begin
      rdy[LAST-i] = !valid_q[LAST-i] || r;
      r           = rdy[LAST-i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        valid_q[s] <= 1'b0;
        a_q[s]     <= '0;
        b_q[s]     <= '0;
        op_q[s]    <= 1'b0;
        c_q[s]     <= 1'b0;
        sum_q[s]   <= '0;
      end
      ovf_q <= 1'b0;
    end else begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        if (rdy[s]) begin
          valid_q[s] <= valid_src[s];
          // Data only moves with a valid op, so a drained pipe keeps its
          // last result on the outputs.
          if (valid_src[s]) begin
            a_q[s]   <= a_src[s];
            b_q[s]   <= b_src[s];
            op_q[s]  <= op_src[s];
            c_q[s]   <= c_nx[s];
            sum_q[s] <= sum_nx[s];
          end
        end
      end
      if (rdy[LAST] && valid_src[LAST]) begin
        ovf_q <= ovf_nx;
      end
    end
  end

  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = valid_q[LAST];
  assign bus.sum       = sum_q[LAST];
  assign bus.cout      = c_q[LAST];
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder (WIDTH=32, GROUP=4, STAGES=2).
// Expected results are queued from a behavioural model when operands are
// accepted; observed results are queued when the DUT hands one off.
module tb_pipelined_cla_adder;
  import cla_pkg::*;

  localparam int unsigned W   = 32;
  localparam int          LAT = 2;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           cyc;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  bit   rnd_done = 1'b0;
  res_t exp_q[$];
  res_t obs_q[$];

  pipelined_cla_adder_if #(.WIDTH(W)) bus ();

  pipelined_cla_adder #(.WIDTH(W), .GROUP(4), .STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic res_t model(logic [W-1:0] a, logic [W-1:0] b, logic c, logic o, int at);
    res_t r;
    logic [W:0]   t;
    logic [W-1:0] be;
    be     = o ? ~b : b;
    t      = {1'b0, a} + {1'b0, be} + (o ? {{W{1'b0}}, 1'b1} : {{W{1'b0}}, c});
    r.sum  = t[W-1:0];
    r.cout = t[W];
    r.ovf  = (a[W-1] == be[W-1]) && (t[W-1] != a[W-1]);
    r.cyc  = at;
    return r;
  endfunction

  // Both handshakes complete on the coming rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid && bus.out_ready)
        obs_q.push_back('{sum: bus.sum, cout: bus.cout, ovf: bus.ovf, cyc: cyc});
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.in1, bus.in2, bus.cin, bus.op, cyc));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic drive_op(logic [W-1:0] a, logic [W-1:0] b, logic c, logic o);
    int n = 0;
    bus.in1 = a; bus.in2 = b; bus.cin = c; bus.op = o; bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      fails++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1");
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_results(int n);
    int t = 0;
    while (obs_q.size() < n && t < 200) begin @(negedge clk); t++; end
    @(posedge clk); #1;
  endtask

  task automatic take(output res_t o, output res_t e, output bit ok);
    ok = (obs_q.size() > 0) && (exp_q.size() > 0);
    o = '{sum: '0, cout: 1'b0, ovf: 1'b0, cyc: 0};
    e = o;
    if (ok) begin o = obs_q.pop_front(); e = exp_q.pop_front(); end
  endtask

  task automatic test_reset();
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
    checks++; if (bus.sum !== '0 || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
      fails++; $display("FAIL reset_outputs: got sum=%h cout=%b ovf=%b required zeros", bus.sum, bus.cout, bus.ovf); end
    checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready); end
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0; bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (obs_q.size() != 0 || exp_q.size() != 0) begin
      fails++; $display("FAIL reset_no_result: got %0d results %0d accepts required 0", obs_q.size(), exp_q.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_add_carry();
    res_t o, e; bit ok;
    bus.out_ready = 1'b1;
    drive_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD);
    drive_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD);
    bus.in_valid = 1'b0;
    wait_results(2);
    checks++; if (obs_q.size() != 2) begin fails++; $display("FAIL add_count: got %0d required 2", obs_q.size()); end
    take(o, e, ok);
    checks++; if (!ok || {o.cout, o.ovf, o.sum} !== {1'b1, 1'b0, 32'h0000_0000}) begin
      fails++; $display("FAIL add_carry_chain: got cout=%b ovf=%b sum=%h required 1 0 00000000", o.cout, o.ovf, o.sum); end
    checks++; if (!ok || (o.cyc - e.cyc) != LAT) begin fails++; $display("FAIL add_latency: got %0d required %0d", o.cyc - e.cyc, LAT); end
    take(o, e, ok);
    checks++; if (!ok || {o.cout, o.ovf, o.sum} !== {1'b0, 1'b1, 32'h8000_0000}) begin
      fails++; $display("FAIL add_overflow: got cout=%b ovf=%b sum=%h required 0 1 80000000", o.cout, o.ovf, o.sum); end
  endtask

  task automatic test_sub();
    res_t o, e; bit ok;
    bus.out_ready = 1'b1;
    drive_op(32'd5, 32'd7, 1'b1, OP_SUB);
    drive_op(32'h8000_0000, 32'd1, 1'b0, OP_SUB);
    bus.in_valid = 1'b0;
    wait_results(2);
    checks++; if (obs_q.size() != 2) begin fails++; $display("FAIL sub_count: got %0d required 2", obs_q.size()); end
    take(o, e, ok);
    checks++; if (!ok || {o.cout, o.ovf, o.sum} !== {1'b0, 1'b0, 32'hFFFF_FFFE}) begin
      fails++; $display("FAIL sub_borrow: got cout=%b ovf=%b sum=%h required 0 0 fffffffe", o.cout, o.ovf, o.sum); end
    take(o, e, ok);
    checks++; if (!ok || {o.cout, o.ovf, o.sum} !== {1'b1, 1'b1, 32'h7FFF_FFFF}) begin
      fails++; $display("FAIL sub_overflow: got cout=%b ovf=%b sum=%h required 1 1 7fffffff", o.cout, o.ovf, o.sum); end
  endtask

  task automatic test_streaming();
    res_t o, e; bit ok; int first;
    bus.out_ready = 1'b1;
    for (int unsigned i = 0; i < 8; i++) drive_op(W'(i), W'(3 * i), 1'b0, OP_ADD);
    bus.in_valid = 1'b0;
    wait_results(8);
    checks++; if (obs_q.size() != 8) begin fails++; $display("FAIL stream_count: got %0d required 8", obs_q.size()); end
    first = (exp_q.size() > 0) ? exp_q[0].cyc : 0;
    for (int unsigned i = 0; i < 8; i++) begin
      take(o, e, ok);
      checks++; if (!ok || {o.cout, o.ovf, o.sum} !== {1'b0, 1'b0, W'(4 * i)}) begin
        fails++; $display("FAIL stream_sum[%0d]: got %h required %h", i, o.sum, W'(4 * i)); end
      checks++; if (!ok || o.cyc != first + LAT + int'(i)) begin
        fails++; $display("FAIL stream_cycle[%0d]: got %0d required %0d", i, o.cyc, first + LAT + int'(i)); end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] av[6], bv[6], held;
    res_t o, e; bit ok, have;
    int k, t;
    for (int unsigned i = 0; i < 6; i++) begin av[i] = $urandom; bv[i] = $urandom; end
    k = 0; t = 0; have = 1'b0; held = '0;
    bus.out_ready = 1'b0;
    while (k < 6 && t < 100) begin
      if (t == 5) bus.out_ready = 1'b1;
      bus.in1 = av[k]; bus.in2 = bv[k]; bus.cin = k[0]; bus.op = k[1]; bus.in_valid = 1'b1;
      @(negedge clk);
      if (bus.out_valid && !bus.out_ready) begin
        if (!have) begin held = bus.sum; have = 1'b1; end
        else begin
          checks++; if (bus.sum !== held) begin fails++; $display("FAIL bp_stable: got %h required %h", bus.sum, held); end
        end
      end
      if (t == 4) begin
        checks++; if (bus.in_ready !== 1'b0 || k != 2) begin
          fails++; $display("FAIL bp_in_ready: got in_ready=%b accepts=%0d required 0 and 2", bus.in_ready, k); end
      end
      if (bus.in_valid && bus.in_ready) k++;
      t++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    wait_results(6);
    repeat (4) @(negedge clk);
    checks++; if (obs_q.size() != 6) begin fails++; $display("FAIL bp_count: got %0d required 6", obs_q.size()); end
    for (int unsigned i = 0; i < 6; i++) begin
      take(o, e, ok);
      checks++; if (!ok || {o.cout, o.ovf, o.sum} !== {e.cout, e.ovf, e.sum}) begin
        fails++; $display("FAIL bp_order[%0d]: got %b %b %h required %b %b %h", i, o.cout, o.ovf, o.sum, e.cout, e.ovf, e.sum); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midflight();
    res_t o, e; bit ok;
    bus.out_ready = 1'b0;
    drive_op(32'd100, 32'd200, 1'b0, OP_ADD);
    drive_op(32'd300, 32'd400, 1'b0, OP_ADD);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    bus.out_ready = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (obs_q.size() != 0 || bus.out_valid !== 1'b0) begin
      fails++; $display("FAIL midflight_discard: got %0d results out_valid=%b required 0", obs_q.size(), bus.out_valid); end
    @(posedge clk); #1;
    drive_op(32'h1234_5678, 32'h1111_1111, 1'b1, OP_ADD);
    bus.in_valid = 1'b0;
    wait_results(1);
    take(o, e, ok);
    checks++; if (!ok || {o.cout, o.ovf, o.sum} !== {1'b0, 1'b0, 32'h2345_678A}) begin
      fails++; $display("FAIL midflight_next: got %b %b %h required 0 0 2345678a", o.cout, o.ovf, o.sum); end
    checks++; if (!ok || (o.cyc - e.cyc) != LAT) begin fails++; $display("FAIL midflight_latency: got %0d required %0d", o.cyc - e.cyc, LAT); end
  endtask

  task automatic test_random();
    res_t o, e; bit ok;
    rnd_done = 1'b0;
    fork
      begin
        while (!rnd_done) begin
          bus.out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
      end
    join_none
    for (int unsigned i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) begin bus.in_valid = 1'b0; @(posedge clk); #1; end
      drive_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    bus.in_valid = 1'b0;
    rnd_done = 1'b1;
    @(posedge clk); #2;
    bus.out_ready = 1'b1;
    wait_results(24);
    checks++; if (obs_q.size() != 24) begin fails++; $display("FAIL rand_count: got %0d required 24", obs_q.size()); end
    for (int unsigned i = 0; i < 24; i++) begin
      take(o, e, ok);
      checks++; if (!ok || {o.cout, o.ovf, o.sum} !== {e.cout, e.ovf, e.sum}) begin
        fails++; $display("FAIL rand[%0d]: got %b %b %h required %b %b %h", i, o.cout, o.ovf, o.sum, e.cout, e.ovf, e.sum); end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b1;
    bus.in1       = 32'hDEAD_BEEF;
    bus.in2       = 32'h0BAD_F00D;
    bus.cin       = 1'b0;
    bus.op        = OP_ADD;
    bus.out_ready = 1'b1;
    test_reset();
    test_add_carry();
    test_sub();
    test_streaming();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
